// File: rtl/bram_arb_pkg.sv
// Types and constants shared by the BRAM round-robin arbiter and its storage.
package bram_arb_pkg;

   localparam int MAX_NREQ = 4;
   localparam int IDW      = $clog2(MAX_NREQ);

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic           valid;
      logic [IDW-1:0] id;
   } rsp_tag_t;

endpackage

// File: rtl/libstd.sv
// Shared helper package: small constant functions used for parameter sizing.
package libstd;

   // Address width for a given depth: ceil(log2(n)), never less than 1.
   function automatic int log2x(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bram_sp_readfirst.sv
// Single-port read-first block RAM with optional output register.
// Read latency is 1 + DOREG cycles; memory contents are never reset,
// only the read-path registers are cleared by rst (active high).
module bram_sp_readfirst
   import libstd::*;
#(
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 1024,
   parameter int DOREG  = 1,
   localparam int AW    = log2x(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DWIDTH-1:0] wdata_i,
   output logic [DWIDTH-1:0] rdata_o
);

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] rd_q;

   // Storage write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (en_i && we_i) mem_q[addr_i] <= wdata_i;
   end

   // Read-first capture: returns the word as it was before this cycle's write.
   always_ff @(posedge clk) begin
      if (rst) rd_q <= '0;
      else if (en_i) rd_q <= mem_q[addr_i];
   end

   generate
      if (DOREG != 0) begin : g_doreg
         logic [DWIDTH-1:0] do_q;
         // Output register stage, advances every cycle to keep latency fixed.
         always_ff @(posedge clk) begin
            if (rst) do_q <= '0;
            else do_q <= rd_q;
         end
         assign rdata_o = do_q;
      end else begin : g_nodoreg
         assign rdata_o = rd_q;
      end
   endgenerate

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter giving NREQ requesters shared access to one read-first
// BRAM. Responses are tracked by an L = 1+DOREG stage {valid,id} tag pipeline.
// Optional grant locking is compiled in with BRAM_ARB_LOCK_EN.
//
//   state  | meaning
//   ARB    | round-robin search from ptr+1 among valid requesters
//   LOCKED | only owner may transfer; owner transfer with lock=0 releases
module bram_rr_arbiter
   import bram_arb_pkg::*;
   import libstd::*;
#(
   parameter int NREQ   = 2,
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 1024,
   parameter int DOREG  = 1,
   localparam int AW    = log2x(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ-1:0]        req_lock,
   input  logic [NREQ*AW-1:0]     req_addr,
   input  logic [NREQ*DWIDTH-1:0] req_wdata,
   output logic [NREQ-1:0]        req_ready,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DWIDTH-1:0]      rsp_rdata,
   output logic                   busy
);

   localparam int LAT = 1 + ((DOREG != 0) ? 1 : 0);
   localparam int CW  = IDW + 1;

   logic [MAX_NREQ-1:0] valid_ext;
   logic [IDW-1:0]      ptr_q;
   logic [IDW-1:0]      grant_idx;
   logic                grant_vld;
   logic                xfer;
   logic                lock_hold;
   logic [IDW-1:0]      lock_owner;
   logic [AW-1:0]       mem_addr;
   logic [DWIDTH-1:0]   mem_wdata;
   logic [DWIDTH-1:0]   mem_rdata;
   logic                mem_we;
   logic                tag_busy;
   rsp_tag_t            tag_q [LAT];

   assign valid_ext = MAX_NREQ'(req_valid);

`ifdef BRAM_ARB_LOCK_EN
   arb_state_t          state_q;
   logic [IDW-1:0]      owner_q;
   logic [MAX_NREQ-1:0] lock_ext;

   assign lock_ext   = MAX_NREQ'(req_lock);
   assign lock_hold  = (state_q == LOCKED);
   assign lock_owner = owner_q;

   // Lock FSM: a locked transfer in ARB captures the owner; the owner's
   // unlocked transfer releases it. An idle owner keeps the lock indefinitely.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ARB;
         owner_q <= '0;
      end else if (xfer) begin
         case (state_q)
            ARB: begin
               if (lock_ext[grant_idx]) begin
                  state_q <= LOCKED;
                  owner_q <= grant_idx;
               end
            end
            LOCKED: begin
               if (!lock_ext[grant_idx]) state_q <= ARB;
            end
            default: state_q <= ARB;
         endcase
      end
   end
`else
   logic unused_lock;

   assign unused_lock = ^req_lock;
   assign lock_hold   = 1'b0;
   assign lock_owner  = '0;
`endif

   // Grant selection: locked owner, else first valid requester after ptr.
   always_comb begin
      logic [CW-1:0] cand;
      cand      = '0;
      grant_idx = ptr_q;
      grant_vld = 1'b0;
      if (lock_hold) begin
         grant_idx = lock_owner;
         grant_vld = valid_ext[lock_owner];
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
            if (!grant_vld && valid_ext[cand[IDW-1:0]]) begin
               grant_vld = 1'b1;
               grant_idx = cand[IDW-1:0];
            end
         end
      end
      grant_vld = grant_vld & rst;
   end

   assign xfer = grant_vld;

   // One-hot ready for the selected requester.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = grant_vld && (grant_idx == IDW'(i));
      end
   end

   // Route the granted requester's access to storage.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            mem_addr  = req_addr[i*AW +: AW];
            mem_wdata = req_wdata[i*DWIDTH +: DWIDTH];
            mem_we    = xfer & req_we[i];
         end
      end
   end

   // Round-robin pointer and response tag pipeline.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q <= IDW'(NREQ - 1);
         for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
      end else begin
         if (xfer) ptr_q <= grant_idx;
         tag_q[0] <= '{valid: xfer, id: grant_idx};
         for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
      end
   end

   // Decode the last tag stage into the per-requester response pulse.
   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_valid[i] = tag_q[LAT-1].valid && (tag_q[LAT-1].id == IDW'(i));
      end
   end

   // Any access still in flight.
   always_comb begin
      tag_busy = 1'b0;
      for (int s = 0; s < LAT; s++) tag_busy = tag_busy | tag_q[s].valid;
   end

   assign rsp_rdata = (|rsp_valid) ? mem_rdata : '0;
   assign busy      = tag_busy | lock_hold;

   bram_sp_readfirst #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .DOREG  (DOREG)
   ) u_mem (
      .clk     (clk),
      .rst     (~rst),
      .en_i    (xfer),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Bench for bram_rr_arbiter: instance A (2 requesters, DOREG=1) and
// instance B (3 requesters, 16-bit, DOREG=0), directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_bram_rr_arbiter;

   localparam int A_N = 2, A_DW = 32, A_DEPTH = 1024, A_AW = 10, A_LAT = 2;
   localparam int B_N = 3, B_DW = 16, B_DEPTH = 16,   B_AW = 4,  B_LAT = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [A_N-1:0]      a_valid, a_we, a_lock, a_ready, a_rsp_valid;
   logic [A_N*A_AW-1:0] a_addr;
   logic [A_N*A_DW-1:0] a_wdata;
   logic [A_DW-1:0]     a_rdata;
   logic                a_busy;

   logic [B_N-1:0]      b_valid, b_we, b_lock, b_ready, b_rsp_valid;
   logic [B_N*B_AW-1:0] b_addr;
   logic [B_N*B_DW-1:0] b_wdata;
   logic [B_DW-1:0]     b_rdata;
   logic                b_busy;

   bram_rr_arbiter #(.NREQ(A_N), .DWIDTH(A_DW), .DEPTH(A_DEPTH), .DOREG(1)) dut_a (
      .clk(clk), .rst(rst), .req_valid(a_valid), .req_we(a_we), .req_lock(a_lock),
      .req_addr(a_addr), .req_wdata(a_wdata), .req_ready(a_ready),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .busy(a_busy));

   bram_rr_arbiter #(.NREQ(B_N), .DWIDTH(B_DW), .DEPTH(B_DEPTH), .DOREG(0)) dut_b (
      .clk(clk), .rst(rst), .req_valid(b_valid), .req_we(b_we), .req_lock(b_lock),
      .req_addr(b_addr), .req_wdata(b_wdata), .req_ready(b_ready),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .busy(b_busy));

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      int          cyc;
      int          id;
      logic [31:0] data;
   } exp_t;

   logic [31:0] mem_a [int];
   logic [31:0] mem_b [int];

   function automatic logic [31:0] mem_read(input int sel, input int a);
      if (sel == 0) return mem_a.exists(a) ? mem_a[a] : 32'h0;
      return mem_b.exists(a) ? mem_b[a] : 32'h0;
   endfunction

   function automatic void mem_write(input int sel, input int a, input logic [31:0] d);
      if (sel == 0) mem_a[a] = d;
      else mem_b[a] = d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      a_valid = '0; a_we = '0; a_lock = '0; a_addr = '0; a_wdata = '0;
      b_valid = '0; b_we = '0; b_lock = '0; b_addr = '0; b_wdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      a_valid = 2'b11;
      b_valid = 3'b111;
      @(negedge clk);
      n_total++;
      if (a_ready !== 2'b00) $display("FAIL reset_ready_a: got %b expected 00", a_ready);
      else n_pass++;
      n_total++;
      if (b_ready !== 3'b000) $display("FAIL reset_ready_b: got %b expected 000", b_ready);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if (a_rsp_valid !== 2'b00 || a_rdata !== 32'h0 || a_busy !== 1'b0)
         $display("FAIL reset_outputs_a: got rsp=%b rdata=%h busy=%b expected 00/0/0",
                  a_rsp_valid, a_rdata, a_busy);
      else n_pass++;
      n_total++;
      if (b_busy !== 1'b0) $display("FAIL reset_busy_b: got %b expected 0", b_busy);
      else n_pass++;
      tick();
      clear_inputs();
      rst = 1'b1;
   endtask

   task automatic test_write_read();
      do_reset();
      a_valid = 2'b01; a_we = 2'b01;
      a_addr[0 +: A_AW] = 10'd5;
      a_wdata[0 +: A_DW] = 32'hA5A50001;
      @(negedge clk);
      n_total++;
      if (a_ready !== 2'b01) $display("FAIL wr_ready0: got %b expected 01", a_ready);
      else n_pass++;
      tick();
      a_valid = 2'b10; a_we = 2'b00;
      a_addr[A_AW +: A_AW] = 10'd5;
      @(negedge clk);
      n_total++;
      if (a_ready !== 2'b10) $display("FAIL rd_ready1: got %b expected 10", a_ready);
      else n_pass++;
      n_total++;
      if (a_busy !== 1'b1) $display("FAIL wr_busy: got %b expected 1", a_busy);
      else n_pass++;
      tick();
      a_valid = 2'b00;
      @(negedge clk);
      n_total++;
      if (a_rsp_valid !== 2'b01 || a_rdata !== 32'h0)
         $display("FAIL wr_rsp: got rsp=%b rdata=%h expected 01/00000000", a_rsp_valid, a_rdata);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if (a_rsp_valid !== 2'b10 || a_rdata !== 32'hA5A50001)
         $display("FAIL rd_rsp: got rsp=%b rdata=%h expected 10/a5a50001", a_rsp_valid, a_rdata);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if (a_rsp_valid !== 2'b00 || a_rdata !== 32'h0 || a_busy !== 1'b0)
         $display("FAIL wr_rd_idle: got rsp=%b rdata=%h busy=%b expected 00/0/0",
                  a_rsp_valid, a_rdata, a_busy);
      else n_pass++;
      tick();
   endtask

   task automatic test_alternate();
      logic [1:0] exp_r;
      do_reset();
      a_valid = 2'b11;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp_r = (c % 2 == 0) ? 2'b01 : 2'b10;
         n_total++;
         if (a_ready !== exp_r) $display("FAIL alt_ready c=%0d: got %b expected %b", c, a_ready, exp_r);
         else n_pass++;
         if (c >= 2) begin
            exp_r = ((c - 2) % 2 == 0) ? 2'b01 : 2'b10;
            n_total++;
            if (a_rsp_valid !== exp_r)
               $display("FAIL alt_rsp c=%0d: got %b expected %b", c, a_rsp_valid, exp_r);
            else n_pass++;
         end
         tick();
      end
      clear_inputs();
      repeat (3) tick();
   endtask

   task automatic test_reset_discard();
      do_reset();
      a_valid = 2'b01;
      a_addr[0 +: A_AW] = 10'd5;
      @(negedge clk);
      n_total++;
      if (a_ready !== 2'b01) $display("FAIL disc_ready: got %b expected 01", a_ready);
      else n_pass++;
      tick();
      rst = 1'b0;
      a_valid = 2'b11;
      @(negedge clk);
      n_total++;
      if (a_ready !== 2'b00) $display("FAIL disc_ready_in_reset: got %b expected 00", a_ready);
      else n_pass++;
      tick();
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if (a_rsp_valid !== 2'b00 || a_busy !== 1'b0)
         $display("FAIL disc_rsp: got rsp=%b busy=%b expected 00/0", a_rsp_valid, a_busy);
      else n_pass++;
      n_total++;
      if (a_ready !== 2'b01) $display("FAIL disc_first_grant: got %b expected 01", a_ready);
      else n_pass++;
      tick();
      clear_inputs();
      repeat (3) tick();
   endtask

`ifdef BRAM_ARB_LOCK_EN
   task automatic test_lock_hold();
      do_reset();
      a_valid = 2'b11; a_lock = 2'b01; a_we = 2'b00;
      a_addr = {10'd7, 10'd7};
      @(negedge clk);
      n_total++;
      if (a_ready !== 2'b01) $display("FAIL lock_grant: got %b expected 01", a_ready);
      else n_pass++;
      tick();
      for (int c = 1; c <= 3; c++) begin
         a_valid = 2'b10;
         @(negedge clk);
         n_total++;
         if (a_ready !== 2'b00) $display("FAIL lock_hold c=%0d: got %b expected 00", c, a_ready);
         else n_pass++;
         if (c == 3) begin
            n_total++;
            if (a_busy !== 1'b1) $display("FAIL lock_busy: got %b expected 1", a_busy);
            else n_pass++;
         end
         tick();
      end
      a_valid = 2'b11; a_we = 2'b01; a_lock = 2'b00;
      a_wdata[0 +: A_DW] = 32'h00007777;
      @(negedge clk);
      n_total++;
      if (a_ready !== 2'b01) $display("FAIL lock_release: got %b expected 01", a_ready);
      else n_pass++;
      tick();
      a_we = 2'b00;
      @(negedge clk);
      n_total++;
      if (a_ready !== 2'b10) $display("FAIL lock_after: got %b expected 10", a_ready);
      else n_pass++;
      tick();
      clear_inputs();
      repeat (3) tick();
   endtask
`endif

   task automatic test_doreg0();
      logic [2:0] exp_r;
      do_reset();
      b_valid = 3'b001;
      b_addr[0 +: B_AW] = 4'd3;
      @(negedge clk);
      n_total++;
      if (b_ready !== 3'b001) $display("FAIL d0_ready: got %b expected 001", b_ready);
      else n_pass++;
      tick();
      b_valid = 3'b000;
      @(negedge clk);
      n_total++;
      if (b_rsp_valid !== 3'b001 || b_rdata !== 16'h0)
         $display("FAIL d0_rsp: got rsp=%b rdata=%h expected 001/0000", b_rsp_valid, b_rdata);
      else n_pass++;
      tick();
      @(negedge clk);
      n_total++;
      if (b_rsp_valid !== 3'b000) $display("FAIL d0_pulse: got %b expected 000", b_rsp_valid);
      else n_pass++;
      tick();
`ifndef BRAM_ARB_LOCK_EN
      do_reset();
      b_valid = 3'b011;
      b_lock  = 3'b111;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         exp_r = (c % 2 == 0) ? 3'b001 : 3'b010;
         n_total++;
         if (b_ready !== exp_r) $display("FAIL nolock_ready c=%0d: got %b expected %b", c, b_ready, exp_r);
         else n_pass++;
         if (c >= 1) begin
            exp_r = ((c - 1) % 2 == 0) ? 3'b001 : 3'b010;
            n_total++;
            if (b_rsp_valid !== exp_r)
               $display("FAIL nolock_rsp c=%0d: got %b expected %b", c, b_rsp_valid, exp_r);
            else n_pass++;
         end
         tick();
      end
      clear_inputs();
      repeat (2) tick();
`endif
   endtask

   task automatic test_random(input int sel, input int ncyc);
      exp_t        q[$];
      exp_t        e;
      int          n, lat, last, owner, g;
      bit          locked, rst_now;
      logic [3:0]  v, we, lk, rdy, rv, exp_rdy, exp_rv;
      logic [31:0] rd, exp_rd, dmask;
      logic        bz, exp_bz;
      int          addr [4];
      logic [31:0] wd [4];
      n      = (sel == 0) ? A_N : B_N;
      lat    = (sel == 0) ? A_LAT : B_LAT;
      dmask  = (sel == 0) ? 32'hFFFFFFFF : 32'h0000FFFF;
      last   = n - 1;
      locked = 1'b0;
      owner  = 0;
      clear_inputs();
      for (int c = 0; c < ncyc; c++) begin
         rst_now = (c == 0) || ($urandom_range(0, 49) == 0);
         v  = 4'($urandom_range(0, 15));
         we = 4'($urandom_range(0, 15));
         lk = 4'($urandom) & 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            addr[i] = (sel == 0) ? 16 + int'($urandom_range(0, 7)) : int'($urandom_range(0, 15));
            wd[i]   = $urandom & dmask;
         end
         rst = !rst_now;
         if (sel == 0) begin
            a_valid = v[1:0]; a_we = we[1:0]; a_lock = lk[1:0];
            for (int i = 0; i < A_N; i++) begin
               a_addr[i*A_AW +: A_AW]  = A_AW'(addr[i]);
               a_wdata[i*A_DW +: A_DW] = wd[i];
            end
         end else begin
            b_valid = v[2:0]; b_we = we[2:0]; b_lock = lk[2:0];
            for (int i = 0; i < B_N; i++) begin
               b_addr[i*B_AW +: B_AW]  = B_AW'(addr[i]);
               b_wdata[i*B_DW +: B_DW] = wd[i][15:0];
            end
         end

         g = -1;
         if (!rst_now) begin
            if (locked) begin
               if (v[owner]) g = owner;
            end else begin
               for (int k = 1; k <= n; k++) begin
                  if (g < 0 && v[(last + k) % n]) g = (last + k) % n;
               end
            end
         end
         exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
         exp_rv  = 4'b0;
         exp_rd  = 32'h0;
         if (q.size() > 0 && q[0].cyc == c) begin
            exp_rv = 4'(1 << q[0].id);
            exp_rd = q[0].data;
         end
         exp_bz = (q.size() > 0) || locked;

         @(negedge clk);
         rdy = (sel == 0) ? 4'(a_ready)     : 4'(b_ready);
         rv  = (sel == 0) ? 4'(a_rsp_valid) : 4'(b_rsp_valid);
         rd  = (sel == 0) ? a_rdata         : 32'(b_rdata);
         bz  = (sel == 0) ? a_busy          : b_busy;
         n_total++;
         if (rdy !== exp_rdy) $display("FAIL rand%0d_ready c=%0d: got %b expected %b", sel, c, rdy, exp_rdy);
         else n_pass++;
         n_total++;
         if (rv !== exp_rv) $display("FAIL rand%0d_rsp c=%0d: got %b expected %b", sel, c, rv, exp_rv);
         else n_pass++;
         n_total++;
         if (rd !== exp_rd) $display("FAIL rand%0d_rdata c=%0d: got %h expected %h", sel, c, rd, exp_rd);
         else n_pass++;
         n_total++;
         if (bz !== exp_bz) $display("FAIL rand%0d_busy c=%0d: got %b expected %b", sel, c, bz, exp_bz);
         else n_pass++;

         if (q.size() > 0 && q[0].cyc == c) void'(q.pop_front());
         if (rst_now) begin
            q.delete();
            locked = 1'b0;
            last   = n - 1;
         end else if (g >= 0) begin
            e.cyc  = c + lat;
            e.id   = g;
            e.data = mem_read(sel, addr[g]);
            if (we[g]) mem_write(sel, addr[g], wd[g]);
            q.push_back(e);
            last = g;
`ifdef BRAM_ARB_LOCK_EN
            if (!locked && lk[g]) begin
               locked = 1'b1;
               owner  = g;
            end else if (locked && !lk[g]) begin
               locked = 1'b0;
            end
`endif
         end
         tick();
      end
      rst = 1'b1;
      clear_inputs();
      repeat (lat + 1) tick();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      tick();
      test_reset();
      test_write_read();
      test_alternate();
      test_reset_discard();
`ifdef BRAM_ARB_LOCK_EN
      test_lock_hold();
`endif
      test_doreg0();
      test_random(0, 400);
      test_random(1, 400);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bram_rr_arbiter.md
BRAM_RR_ARBITER -- requirements
Module: bram_rr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2: number of requesters, legal 2..4.
REQ-002 SHALL have parameter DWIDTH, default 32: data width.
REQ-003 SHALL have parameter DEPTH, default 1024: words; AW = log2x(DEPTH).
REQ-004 SHALL have parameter DOREG, default 1: storage output register enable.
REQ-005 SHALL have port clk, input, 1: sole clock; all state changes on rising edge only.
REQ-006 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, NREQ: request present, per requester.
REQ-008 SHALL have port req_we, input, NREQ: 1 = write, 0 = read.
REQ-009 SHALL have port req_lock, input, NREQ: hold grant after this transfer.
REQ-010 SHALL have port req_addr, input, NREQ x AW: word address.
REQ-011 SHALL have port req_wdata, input, NREQ x DWIDTH: write data.
REQ-012 SHALL have port req_ready, output, NREQ: grant; transfer when valid & ready.
REQ-013 SHALL have port rsp_valid, output, NREQ: one-cycle response pulse, per requester.
REQ-014 SHALL have port rsp_rdata, output, DWIDTH: shared response data.
REQ-015 SHALL have port busy, output, 1: access in flight or lock held.

Function
REQ-016 req_ready SHALL be at most one-hot, combinational from req_valid and state, and never set for a requester whose req_valid is 0.
REQ-017 Round robin SHALL apply: search starts at ptr+1 mod NREQ; ptr <= granted index on transfer; ptr unchanged otherwise.
REQ-018 The granted access SHALL drive the storage in the transfer cycle; storage we = 0 in cycles with no transfer.
REQ-019 Every transfer, read or write, SHALL return pre-write (read-first) data: rsp_valid[id] pulses exactly one cycle, L = 1+DOREG cycles after the transfer cycle.
REQ-020 An L-stage tag pipeline {valid, id} SHALL track responses; back-to-back transfers yield back-to-back in-order responses; no response backpressure.
REQ-021 rsp_rdata SHALL be 0 whenever no rsp_valid bit is set.
REQ-022 A write at cycle T SHALL be visible to any transfer at T+1 or later.
REQ-023 State machine ARB / LOCKED(owner): in ARB, a transfer with req_lock=1 SHALL go to LOCKED with owner = i.
REQ-024 In LOCKED, only owner SHALL receive ready; owner transfer with lock=1 stays; lock=0 returns to ARB after that transfer; owner valid low stays LOCKED (no timeout).
REQ-025 busy SHALL = any tag valid OR state == LOCKED.

Reset
REQ-026 rst=0 at an edge SHALL force: state ARB, ptr = NREQ-1, tags cleared, rsp_valid = 0, rsp_rdata = 0, busy = 0.
REQ-027 req_ready SHALL be 0 in every cycle where rst=0.
REQ-028 Reset SHALL discard in-flight responses (none emitted afterwards), release any lock, and leave memory contents unchanged.

Configuration
REQ-029 With BRAM_ARB_LOCK_EN defined, REQ-023/024 SHALL apply; undefined, req_lock SHALL be ignored, state permanently ARB, and no LOCKED logic generated.

Structure
REQ-030 Package bram_arb_pkg SHALL hold arb_state_t {ARB, LOCKED}, rsp_tag_t {valid, id}, MAX_NREQ = 4; log2x SHALL be taken from libstd.
REQ-031 Storage SHALL be one bram_sp_readfirst(DWIDTH, DEPTH, DOREG) sub-instance with its rst driven by ~rst; arbitration and tags SHALL live in this module.

Verification
REQ-032 NREQ=2, DOREG=1: req0 write addr 5 data 0xA5A50001 at T -> ready0 at T, rsp_valid[0] at T+2 with rdata 0; req1 read addr 5 at T+1 -> rsp_valid[1] at T+3, rdata 0xA5A50001.
REQ-033 Both requesters valid, reads, from reset release -> grants 0,1,0,1; rsp_valid alternates [0],[1],... two cycles behind each grant.
REQ-034 LOCK_EN: req0 read addr 7 lock=1, req1 valid throughout -> req1 ready stays 0 until req0 writes addr 7 with lock=0; req1 is granted the next cycle.
REQ-035 Transfer at T, rst=0 at T+1 -> no rsp_valid at T+2, busy=0; after release with both valid, req0 is granted first.
REQ-036 DOREG=0: read at T -> rsp_valid at T+1; LOCK_EN undefined with req_lock=1 -> alternation of REQ-033 unchanged.
